// File: rtl/jump_ctrl_pkg.sv
// Shared types and constants for the execute-stage jump controller.
// Decoded-op field positions, FSM encodings and result bundle.
package jump_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int OPLEN = 10;

  // decoded_op layout: [2:0] funct3, [3] must_jump,
  // [4] is_branch, [5] is_jalr, [9:6] other decode bits
  localparam int DOP_FUNCT3    = 0;
  localparam int DOP_MUST_JUMP = 3;
  localparam int DOP_BRANCH    = 4;
  localparam int DOP_JALR      = 5;

  typedef enum logic [1:0] {
    JC_RUN      = 2'd0,
    JC_REDIRECT = 2'd1,
    JC_FLUSH    = 2'd2
  } jc_state_t;

  typedef struct packed {
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
  } jt_res_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jump_ctrl_target.sv
// jump_target: combinational target/link adders and alignment check.
// Ports: i_valid, i_comp, i_op, i_pc, i_imm, i_rs1 -> o_res bundle.
module jump_target
  import jump_ctrl_pkg::*;
(
  input  logic             i_valid,
  input  logic             i_comp,
  input  logic [OPLEN-1:0] i_op,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1,
  output jt_res_t          o_res
);

  logic            w_jalr;
  logic            w_must;
  logic            w_br;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_tgt;
  logic            w_unused_op;

  assign w_jalr = i_op[DOP_JALR];
  assign w_must = i_op[DOP_MUST_JUMP];
  assign w_br   = i_op[DOP_BRANCH];

  // funct3 and upper decode bits are the comparator's concern
  assign w_unused_op = ^{i_op[OPLEN-1:DOP_JALR+1],
                         i_op[DOP_FUNCT3+2:DOP_FUNCT3]};

  assign w_base = w_jalr ? i_rs1 : i_pc;
  assign w_sum  = w_base + i_imm;
  assign w_tgt  = w_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

  always_comb begin
    o_res          = '0;
    o_res.target   = w_tgt;
    o_res.link     = i_pc + XLEN'(4);
    o_res.taken    = i_valid & (w_must | (w_br & i_comp));
    o_res.misalign = o_res.taken & (w_tgt[1:0] != 2'b00);
  end

endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl: EX-stage branch/jump resolution, redirect handshake, flush.
// In: clk rst valid_de stall_ex comp_out decoded_op_de curr_pc_de imm_de
//     rs1data_de redirect_ack. Out: jump_state_em next_pc_em link_pc_em
//     redirect_req redirect_pc flush_req misalign_exc busy_ex.
module jump_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_de,
  input  logic             stall_ex,
  input  logic             comp_out,
  input  logic [OPLEN-1:0] decoded_op_de,
  input  logic [XLEN-1:0]  curr_pc_de,
  input  logic [XLEN-1:0]  imm_de,
  input  logic [XLEN-1:0]  rs1data_de,
  input  logic             redirect_ack,
  output logic             jump_state_em,
  output logic [XLEN-1:0]  next_pc_em,
  output logic [XLEN-1:0]  link_pc_em,
  output logic             redirect_req,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_req,
  output logic             misalign_exc,
  output logic             busy_ex
);

  localparam int CW = cnt_w(FLUSH_CYCLES);
  localparam logic [CW-1:0] CNT_INIT =
    (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

  jc_state_t       r_state;
  jc_state_t       w_next;
  logic [CW-1:0]   r_cnt;
  jt_res_t         w_res;
  logic            w_cap;
  logic            w_go;
  logic            r_js;
  logic            r_mis;
  logic [XLEN-1:0] r_next;
  logic [XLEN-1:0] r_link;
  logic [XLEN-1:0] r_rpc;

  jump_target u_tgt (
    .i_valid (valid_de),
    .i_comp  (comp_out),
    .i_op    (decoded_op_de),
    .i_pc    (curr_pc_de),
    .i_imm   (imm_de),
    .i_rs1   (rs1data_de),
    .o_res   (w_res)
  );

  // Only RUN with no stall resolves; REDIRECT/FLUSH see wrong-path ops
  assign w_cap = (r_state == JC_RUN) & ~stall_ex;
  assign w_go  = w_cap & w_res.taken & ~w_res.misalign;

  always_ff @(posedge clk) begin
    if (rst) r_state <= JC_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      JC_RUN: begin
        if (w_go) w_next = JC_REDIRECT;
      end
      JC_REDIRECT: begin
        if (redirect_ack)
          w_next = (FLUSH_CYCLES == 0) ? JC_RUN : JC_FLUSH;
      end
      JC_FLUSH: begin
        if (r_cnt == '0) w_next = JC_RUN;
      end
      default: w_next = JC_RUN;
    endcase
  end

  always_comb begin
    redirect_req = (r_state == JC_REDIRECT);
    flush_req    = (r_state != JC_RUN);
    busy_ex      = (r_state != JC_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == JC_REDIRECT) && redirect_ack) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == JC_FLUSH) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_js   <= 1'b0;
      r_mis  <= 1'b0;
      r_next <= '0;
      r_link <= '0;
      r_rpc  <= '0;
    end else begin
      // exception is a single-cycle pulse, never held by stall
      r_mis <= w_cap & w_res.misalign;
      if (r_state != JC_RUN) begin
        r_js <= 1'b0;
      end else if (!stall_ex) begin
        r_js <= w_go;
        if (valid_de) begin
          r_next <= w_res.taken ? w_res.target : w_res.link;
          r_link <= w_res.link;
        end
      end
      if (w_go) r_rpc <= w_res.target;
    end
  end

  assign jump_state_em = r_js;
  assign misalign_exc  = r_mis;
  assign next_pc_em    = r_next;
  assign link_pc_em    = r_link;
  assign redirect_pc   = r_rpc;

endmodule
